// File: rtl/weighted_misr_checker.sv
`default_nettype none
// ============================================================================
// Module      : weighted_misr_checker
// Description : Response compactor for a weighted LFSR pattern stream.
//               Compacts DATA_W-bit words into a SIG_W-bit MISR while
//               counting accepted words and '1' bits (saturating). At the
//               end of a run the signature is compared with a golden value.
// Ports       : clk, reset_n (sync, active-low)
//               start, seed, golden_sig, num_vectors   - run setup
//               data_valid, data_in                    - word stream
//               busy, done, pass                       - run status
//               signature, vec_count, ones_count       - results
// Revision    : 1.0 - initial release
// ============================================================================
module weighted_misr_checker #(
    parameter int          DATA_W = 5,
    parameter int          SIG_W  = 20,
    parameter logic [19:0] POLY   = 20'h00009,
    parameter int          CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SIG_W-1:0]  seed,
    input  logic [SIG_W-1:0]  golden_sig,
    input  logic [CNT_W-1:0]  num_vectors,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  vec_count,
    output logic [CNT_W-1:0]  ones_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] r_golden;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_vec;
    logic [CNT_W-1:0] r_ones;
    logic             r_pass;

    logic [SIG_W-1:0] w_sig_next;
    logic [CNT_W-1:0] w_pop;
    logic [CNT_W:0]   w_ones_sum;
    logic [CNT_W-1:0] w_ones_next;
    logic [CNT_W-1:0] w_vec_next;

    // MISR step: shift left, fold the MSB back through the taps, XOR the word
    // into the low bits.
    always_comb begin
        w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? SIG_W'(POLY) : '0)
                   ^ {{(SIG_W-DATA_W){1'b0}}, data_in};
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_pop = w_pop + CNT_W'(data_in[i]);
        end
    end

    // One extra bit catches the wrap so the count can stick at all-ones.
    always_comb begin
        w_ones_sum  = {1'b0, r_ones} + {1'b0, w_pop};
        w_ones_next = w_ones_sum[CNT_W] ? '1 : w_ones_sum[CNT_W-1:0];
        w_vec_next  = r_vec + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_sig    <= '0;
            r_golden <= '0;
            r_num    <= '0;
            r_vec    <= '0;
            r_ones   <= '0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A start here wins over any data_valid on the same cycle.
                    if (start) begin
                        r_sig    <= seed;
                        r_golden <= golden_sig;
                        r_num    <= num_vectors;
                        r_vec    <= '0;
                        r_ones   <= '0;
                        if (num_vectors == '0) begin
                            r_state <= S_DONE;
                            r_pass  <= (seed == golden_sig);
                        end else begin
                            r_state <= S_RUN;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (data_valid) begin
                        r_sig  <= w_sig_next;
                        r_vec  <= w_vec_next;
                        r_ones <= w_ones_next;
                        // Compare the post-update signature so pass is valid
                        // on the same cycle done rises.
                        if (w_vec_next == r_num) begin
                            r_state <= S_DONE;
                            r_pass  <= (w_sig_next == r_golden);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass & (r_state == S_DONE);
    assign signature  = r_sig;
    assign vec_count  = r_vec;
    assign ones_count = r_ones;

endmodule
`default_nettype wire

// File: tb/tb_weighted_misr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_weighted_misr_checker
// Description : Directed self-checking bench for weighted_misr_checker.
//               Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weighted_misr_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [19:0] seed;
    logic [19:0] golden_sig;
    logic [31:0] num_vectors;
    logic        data_valid;
    logic [4:0]  data_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [19:0] signature;
    logic [31:0] vec_count;
    logic [31:0] ones_count;

    int n_total  = 0;
    int n_passed = 0;

    weighted_misr_checker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .seed        (seed),
        .golden_sig  (golden_sig),
        .num_vectors (num_vectors),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature),
        .vec_count   (vec_count),
        .ones_count  (ones_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_run(input logic [19:0] s, input logic [19:0] g, input logic [31:0] n);
        start       = 1'b1;
        seed        = s;
        golden_sig  = g;
        num_vectors = n;
        tick();
        start       = 1'b0;
        seed        = 20'hFFFFF;
        golden_sig  = 20'hFFFFF;
        num_vectors = 32'hFFFF_FFFF;
    endtask

    task automatic send(input logic [4:0] d);
        data_valid = 1'b1;
        data_in    = d;
        tick();
        data_valid = 1'b0;
        data_in    = 5'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        seed        = '0;
        golden_sig  = '0;
        num_vectors = '0;
        data_valid  = 1'b0;
        data_in     = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_sig",  32'(signature), 32'd0);
        chk("rst_vec",  vec_count, 32'd0);
        chk("rst_ones", ones_count, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: single word
        start_run(20'h0, 20'h0, 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_done_early", 32'(done), 32'd0);
        send(5'b00001);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_sig",  32'(signature), 32'h00001);
        chk("t1_ones", ones_count, 32'd1);
        chk("t1_vec",  vec_count, 32'd1);
        chk("t1_pass", 32'(pass), 32'd0);

        // 2: two words, golden match then mismatch
        start_run(20'h0, 20'h00002, 32'd2);
        send(5'b00001);
        send(5'b00000);
        chk("t2a_sig",  32'(signature), 32'h00002);
        chk("t2a_pass", 32'(pass), 32'd1);
        start_run(20'h0, 20'h00003, 32'd2);
        send(5'b00001);
        send(5'b00000);
        chk("t2b_done", 32'(done), 32'd1);
        chk("t2b_pass", 32'(pass), 32'd0);

        // 3: MSB feedback through the taps
        start_run(20'h80000, 20'h00009, 32'd1);
        send(5'b00000);
        chk("t3_sig",  32'(signature), 32'h00009);
        chk("t3_pass", 32'(pass), 32'd1);

        // 4: four all-ones words with gaps
        start_run(20'h0, 20'h000A5, 32'd4);
        send(5'b11111);
        tick();
        send(5'b11111);
        tick();
        tick();
        send(5'b11111);
        tick();
        chk("t4_not_done", 32'(done), 32'd0);
        chk("t4_busy",     32'(busy), 32'd1);
        chk("t4_vec3",     vec_count, 32'd3);
        send(5'b11111);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_ones", ones_count, 32'd20);
        chk("t4_vec",  vec_count, 32'd4);
        chk("t4_sig",  32'(signature), 32'h000A5);
        chk("t4_pass", 32'(pass), 32'd1);

        // 5: zero-length run
        start_run(20'hABCDE, 20'hABCDE, 32'd0);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_pass", 32'(pass), 32'd1);
        chk("t5_vec",  vec_count, 32'd0);
        chk("t5_sig",  32'(signature), 32'hABCDE);

        // data_valid in DONE is ignored
        send(5'b10101);
        chk("done_ign_sig",  32'(signature), 32'hABCDE);
        chk("done_ign_ones", ones_count, 32'd0);

        // start with data_valid in DONE: seed load wins
        data_valid = 1'b1;
        data_in    = 5'b11111;
        start_run(20'h12345, 20'h0, 32'd3);
        data_valid = 1'b0;
        chk("sv_sig",  32'(signature), 32'h12345);
        chk("sv_vec",  vec_count, 32'd0);
        chk("sv_busy", 32'(busy), 32'd1);

        // 6: start ignored in RUN, then mid-run reset
        start = 1'b1;
        seed  = 20'h00000;
        num_vectors = 32'd1;
        data_valid = 1'b1;
        data_in    = 5'b00001;
        tick();
        start      = 1'b0;
        data_valid = 1'b0;
        // 0x12345 << 1 ^ 1 = 0x2468B
        chk("t6_sig_noreload", 32'(signature), 32'h2468B);
        chk("t6_vec",  vec_count, 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_sig",  32'(signature), 32'd0);
        chk("t6_rst_vec",  vec_count, 32'd0);
        start_run(20'h0, 20'h00002, 32'd2);
        send(5'b00001);
        send(5'b00000);
        chk("t6_rep_sig",  32'(signature), 32'h00002);
        chk("t6_rep_pass", 32'(pass), 32'd1);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
